// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (I) and data load/store (D).
// Define ARB_STARVE_GUARD_EN to bound how many consecutive D grants may pass a waiting I request.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  latCnt_q, latCnt_d;
    logic              ownerD_q, ownerD_d;
    logic              ownerWe_q, ownerWe_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;
    logic              canArb;
    logic              dWin;
    logic              iWin;

    // Grants are suppressed while reset is held so every output reads zero during reset.
    assign canArb = !rst && ((state_q == IDLE) || (state_q == RESP));

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
    logic                forceI;

    assign forceI = i_req && (starveCnt_q == STARVE_W'(STARVE_MAX));
    assign dWin   = canArb && d_req && !forceI;

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!i_req || i_gnt) begin
            starveCnt_d = '0;
        end else if (d_gnt) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    assign dWin = canArb && d_req;
`endif

    assign iWin = canArb && i_req && !dWin;

    always_comb begin
        state_d   = state_q;
        latCnt_d  = latCnt_q;
        ownerD_d  = ownerD_q;
        ownerWe_d = ownerWe_q;
        iRdata_d  = iRdata_q;
        dRdata_d  = dRdata_q;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (dWin) begin
                    d_gnt     = 1'b1;
                    m_en      = 1'b1;
                    m_we      = d_we;
                    m_addr    = d_addr;
                    m_wdata   = d_wdata;
                    ownerD_d  = 1'b1;
                    ownerWe_d = d_we;
                    latCnt_d  = LAT_INIT;
                    state_d   = WAIT;
                end else if (iWin) begin
                    i_gnt     = 1'b1;
                    m_en      = 1'b1;
                    m_addr    = i_addr;
                    ownerD_d  = 1'b0;
                    ownerWe_d = 1'b0;
                    latCnt_d  = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A store leaves d_rdata holding the most recent load result.
                if (latCnt_q == '0) begin
                    if (ownerD_q) begin
                        if (!ownerWe_q) begin
                            dRdata_d = m_rdata;
                        end
                    end else begin
                        iRdata_d = m_rdata;
                    end
                    state_d = RESP;
                end else begin
                    latCnt_d = latCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            latCnt_q  <= '0;
            ownerD_q  <= 1'b0;
            ownerWe_q <= 1'b0;
            iRdata_q  <= '0;
            dRdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            latCnt_q  <= latCnt_d;
            ownerD_q  <= ownerD_d;
            ownerWe_q <= ownerWe_d;
            iRdata_q  <= iRdata_d;
            dRdata_q  <= dRdata_d;
        end
    end

    assign i_rvalid = (state_q == RESP) && !ownerD_q;
    assign d_rvalid = (state_q == RESP) && ownerD_q;
    assign i_rdata  = iRdata_q;
    assign d_rdata  = dRdata_q;
    assign busy     = (state_q != IDLE);

endmodule
